// File: rtl/scan_index_gen_if.sv
// -----------------------------------------------------------------------------
// scan_index_gen_if
//   Groups the control and index signals of scan_index_gen.
//   master : controller side. It drives start/stop/mode_cont/dwell/last_idx and
//            observes idx/idx_valid/step/busy/done.
//   slave  : scan_index_gen itself.
//   Parameters:
//     N       : index width (decoder input width)
//     DWELL_W : dwell counter / dwell input width
// -----------------------------------------------------------------------------
interface scan_index_gen_if #(
  parameter int N       = 4,
  parameter int DWELL_W = 16
);
  logic               start;
  logic               stop;
  logic               mode_cont;
  logic [DWELL_W-1:0] dwell;
  logic [N-1:0]       last_idx;
  logic [N-1:0]       idx;
  logic               idx_valid;
  logic               step;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, mode_cont, dwell, last_idx,
    input  idx, idx_valid, step, busy, done
  );

  modport slave (
    input  start, stop, mode_cont, dwell, last_idx,
    output idx, idx_valid, step, busy, done
  );
endinterface

// File: rtl/scan_index_gen.sv
// -----------------------------------------------------------------------------
// scan_index_gen
//   Steps an N-bit index from 0 up to a programmable last index L. Each index
//   is held for D+1 cycles. The generator runs one pass (with a done pulse) or
//   wraps continuously. It feeds an N-to-2^N one-hot decoder, and idx_valid
//   qualifies the decoder output.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : scan_index_gen_if.slave
//              in : start, stop, mode_cont, dwell[DWELL_W], last_idx[N]
//              out: idx[N], idx_valid, step, busy, done (all registered)
//
//   Optional feature (macro SCAN_BLANK_EN):
//     Adds a GAP state. GAP inserts one blank cycle (idx_valid=0, idx held)
//     between consecutive indices, including the continuous wrap L->0.
//     When the macro is undefined, GAP and its logic are absent.
// -----------------------------------------------------------------------------
module scan_index_gen #(
  parameter int N       = 4,
  parameter int M       = (1 << N),
  parameter int DWELL_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_index_gen_if.slave  bus
);

`ifdef SCAN_BLANK_EN
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_RUN} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;

  logic [N-1:0]       r_idx,   w_idx_nxt;
  logic [DWELL_W-1:0] r_cnt,   w_cnt_nxt;
  logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
  logic [N-1:0]       r_last,  w_last_nxt;
  logic               r_cont,  w_cont_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_step,  w_step_nxt;
  logic               r_busy,  w_busy_nxt;
  logic               r_done,  w_done_nxt;

  logic               w_hold_over;  // dwell of the current index has expired
  logic               w_at_last;    // current index is the final one of the pass
  logic [N-1:0]       w_idx_inc;
  logic [N-1:0]       w_idx_wrap;   // index that follows the current one

  assign w_hold_over = (r_cnt == '0);
  assign w_at_last   = (r_idx == r_last);
  // Modulo M keeps the full-range case (L = M-1) inside N bits.
  assign w_idx_inc   = N'((int'(r_idx) + 1) % M);
  assign w_idx_wrap  = w_at_last ? '0 : w_idx_inc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments. Every flop
  // therefore samples pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. stop has priority over every other transition.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment at the top of each always_comb is what
    // keeps paths without an explicit assignment from inferring a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hold_over) begin
          if (w_at_last && !r_cont) w_state_nxt = ST_IDLE;
`ifdef SCAN_BLANK_EN
          else                      w_state_nxt = ST_GAP;
`else
          else                      w_state_nxt = ST_RUN;
`endif
        end
      end
`ifdef SCAN_BLANK_EN
      ST_GAP: begin
        w_state_nxt = bus.stop ? ST_IDLE : ST_RUN;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath next values. These are registered below, so all outputs
  // come straight from flops.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_dwell_nxt = r_dwell;
    w_last_nxt  = r_last;
    w_cont_nxt  = r_cont;
    w_step_nxt  = 1'b0;
    w_done_nxt  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Configuration is captured only on an accepted start. Later changes
        // on the inputs have no effect on a scan in progress.
        if (w_state_nxt == ST_RUN) begin
          w_idx_nxt   = '0;
          w_cnt_nxt   = bus.dwell;
          w_dwell_nxt = bus.dwell;
          w_last_nxt  = bus.last_idx;
          w_cont_nxt  = bus.mode_cont;
          w_step_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_state_nxt == ST_IDLE) begin
          // Leaving RUN without stop can only mean a single pass ended.
          w_done_nxt = !bus.stop;
        end else if (!w_hold_over) begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end else if (w_state_nxt == ST_RUN) begin
          w_idx_nxt  = w_idx_wrap;
          w_cnt_nxt  = r_dwell;
          w_step_nxt = 1'b1;
        end
        // A move into GAP keeps idx. The advance happens when GAP exits.
      end
`ifdef SCAN_BLANK_EN
      ST_GAP: begin
        if (w_state_nxt == ST_RUN) begin
          w_idx_nxt  = w_idx_wrap;
          w_cnt_nxt  = r_dwell;
          w_step_nxt = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    w_valid_nxt = (w_state_nxt == ST_RUN);
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_dwell <= '0;
      r_last  <= '0;
      r_cont  <= 1'b0;
      r_valid <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dwell <= w_dwell_nxt;
      r_last  <= w_last_nxt;
      r_cont  <= w_cont_nxt;
      r_valid <= w_valid_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.idx       = r_idx;
  assign bus.idx_valid = r_valid;
  assign bus.step      = r_step;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_scan_index_gen.sv
// -----------------------------------------------------------------------------
// tb_scan_index_gen
//   Self-checking bench for scan_index_gen. A reference model lists the
//   expected per-cycle outputs of each scan (index by index, dwell by dwell).
//   Directed and randomised scans are compared against that list cycle by
//   cycle. Honours SCAN_BLANK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_scan_index_gen;
  localparam int N       = 4;
  localparam int DWELL_W = 16;
`ifdef SCAN_BLANK_EN
  localparam int BLANK = 1;
`else
  localparam int BLANK = 0;
`endif

  typedef struct packed {
    logic [N-1:0] idx;
    logic         valid;
    logic         step;
    logic         busy;
    logic         done;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t exp_q[$];
  logic [N-1:0] model_idx;   // idx the model expects to be held while idle

  scan_index_gen_if #(.N(N), .DWELL_W(DWELL_W)) bus ();

  scan_index_gen #(.N(N), .DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [N-1:0] i, input logic v, input logic s,
                              input logic b, input logic d);
    exp_t e;
    e.idx = i; e.valid = v; e.step = s; e.busy = b; e.done = d;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input exp_t e, input string tag);
    check({tag, ".idx"},       32'(bus.idx),       32'(e.idx));
    check({tag, ".idx_valid"}, 32'(bus.idx_valid), 32'(e.valid));
    check({tag, ".step"},      32'(bus.step),      32'(e.step));
    check({tag, ".busy"},      32'(bus.busy),      32'(e.busy));
    check({tag, ".done"},      32'(bus.done),      32'(e.done));
  endtask

  // Reference model. Each index i in 0..L is valid for D+1 cycles, with a
  // step on the first of them. An optional blank cycle follows each index,
  // except after L in single mode. A single pass ends with a done cycle and
  // then an idle cycle.
  task automatic build_model(input int d, input int l, input bit cont, input int ncyc);
    exp_q.delete();
    do begin
      for (int i = 0; i <= l; i++) begin
        for (int c = 0; c <= d; c++)
          exp_q.push_back(mk(N'(i), 1'b1, (c == 0), 1'b1, 1'b0));
        if (BLANK != 0 && (i < l || cont))
          exp_q.push_back(mk(N'(i), 1'b0, 1'b0, 1'b1, 1'b0));
      end
    end while (cont && exp_q.size() < ncyc);
    if (!cont) begin
      exp_q.push_back(mk(N'(l), 1'b0, 1'b0, 1'b0, 1'b1));
      exp_q.push_back(mk(N'(l), 1'b0, 1'b0, 1'b0, 1'b0));
    end
  endtask

  // Cycle index (from 0 = first cycle after start) of the last valid cycle of L.
  function automatic int last_valid(input int d, input int l);
    return (l + 1) * (d + 1) + l * BLANK - 1;
  endfunction

  // Starts one scan and checks it cycle by cycle. The configuration inputs
  // are scrambled after start, because latched values must not follow them.
  // A start is pulsed after cycle glitch_at and must be ignored. A stop is
  // pulsed after cycle stop_at and must make the next cycle idle.
  task automatic run_scan(input string name, input int d, input int l, input bit cont,
                          input int ncyc, input int stop_at, input int glitch_at);
    int n;
    build_model(d, l, cont, ncyc);
    n = cont ? ncyc : exp_q.size();
    bus.dwell     = DWELL_W'(d);
    bus.last_idx  = N'(l);
    bus.mode_cont = cont;
    bus.stop      = 1'b0;
    bus.start     = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.dwell     = DWELL_W'($urandom);
      bus.last_idx  = N'($urandom);
      bus.mode_cont = 1'($urandom);
      check_outs(exp_q[k], $sformatf("%s[%0d]", name, k));
      model_idx = exp_q[k].idx;
      if (k == glitch_at) bus.start = 1'b1;
      if (k == stop_at) begin
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check_outs(mk(model_idx, 1'b0, 1'b0, 1'b0, 1'b0), $sformatf("%s_stopped", name));
        break;
      end
    end
  endtask

  initial begin
    int d, l, nc, sa, ga, lv;
    bit c;
    errors        = 0;
    checks        = 0;
    model_idx     = '0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mode_cont = 1'b0;
    bus.dwell     = '0;
    bus.last_idx  = '0;

    #3;
    check_outs(mk('0, 1'b0, 1'b0, 1'b0, 1'b0), "reset_state");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;
    check_outs(mk('0, 1'b0, 1'b0, 1'b0, 1'b0), "idle_after_reset");

    // Single pass D=2 L=3, with a start pulse mid-scan that must be ignored.
    run_scan("single", 2, 3, 1'b0, 0, -1, 5);

    // Continuous wrap over the full range, one cycle per index, 40 cycles.
    run_scan("cont_full", 0, 15, 1'b1, 40, 39, -1);

    // Stop at the first cycle of index 2 in continuous mode.
    sa = 2 * (1 + 1 + BLANK);
    run_scan("stop_idx2", 1, 5, 1'b1, sa + 1, sa, -1);

    // L=0 boundaries: single pass, then continuous re-pulse on index 0.
    run_scan("l0_single", 1, 0, 1'b0, 0, -1, -1);
    run_scan("l0_cont", 2, 0, 1'b1, 10, 9, -1);

    // start and stop together in IDLE: stop wins.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_outs(mk(model_idx, 1'b0, 1'b0, 1'b0, 1'b0), "start_stop_idle");
    @(posedge clk); #1;
    check_outs(mk(model_idx, 1'b0, 1'b0, 1'b0, 1'b0), "start_stop_idle2");

    // stop on the edge where the final index completes: no done.
    run_scan("stop_last", 1, 2, 1'b0, 0, last_valid(1, 2), -1);

    // D=1 L=2 single (shows blank pattern when enabled).
    run_scan("d1_l2", 1, 2, 1'b0, 0, -1, -1);

    // Randomised scans.
    for (int r = 0; r < 8; r++) begin
      d  = int'($urandom_range(0, 3));
      l  = int'($urandom_range(0, 15));
      c  = 1'($urandom_range(0, 1));
      lv = last_valid(d, l);
      if (c) begin
        nc = int'($urandom_range(3, 60));
        sa = nc - 1;
      end else begin
        nc = 0;
        sa = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, lv)) : -1;
      end
      ga = (lv >= 2) ? 1 : -1;
      run_scan($sformatf("rand%0d", r), d, l, c, nc, sa, ga);
    end

    // Asynchronous reset while index 3 is being presented.
    build_model(2, 5, 1'b0, 0);
    bus.dwell     = DWELL_W'(2);
    bus.last_idx  = N'(5);
    bus.mode_cont = 1'b0;
    bus.start     = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_outs(exp_q[k], $sformatf("pre_rst[%0d]", k));
      if (exp_q[k].idx == N'(3) && exp_q[k].valid) break;
    end
    #2 rst_n = 1'b0;
    #1;
    check_outs(mk('0, 1'b0, 1'b0, 1'b0, 1'b0), "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_idx = '0;
    @(posedge clk); #1;
    check_outs(mk('0, 1'b0, 1'b0, 1'b0, 1'b0), "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scan_index_gen.md
Name: scan_index_gen

Overview:
- Sequential index generator directly upstream of the N-to-2^N one-hot decoder.
- Steps an N-bit index from 0 up to a programmable last index. Each index is held for a programmable dwell time.
- Runs single-shot or continuous, with a start/stop/done handshake.
- Typical uses: display digit multiplexing, keypad row scanning, round-robin line selection. The decoder turns idx into one-hot select lines.

Parameters:
- N, 4, index width; equals the decoder input width.
- M, (1 << N), number of selectable lines; informational, fixes the idx range 0..M-1.
- DWELL_W, 16, width of the dwell counter and of the dwell input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a scan; honoured only in IDLE.
- stop  input  1  abort request; honoured in any state.
- mode_cont  input  1  1 = continuous wrap-around, 0 = single pass; sampled at accepted start.
- dwell  input  DWELL_W  hold count D; each index is held D+1 cycles; sampled at accepted start.
- last_idx  input  N  final index of the pass (L); sampled at accepted start.
- idx  output  N  current index, to the decoder input.
- idx_valid  output  1  idx is active; the downstream decoder output is qualified by this.
- step  output  1  one-cycle pulse on the first cycle each new index is valid.
- busy  output  1  high in RUN (and GAP when enabled).
- done  output  1  one-cycle pulse at the end of a single pass.

Behaviour:
- Reset (async, rst_n=0): state IDLE; idx=0, idx_valid=0, step=0, busy=0, done=0; dwell counter=0; sampled registers=0. Deassertion is released synchronously by the top level.
- All outputs are registered.
- States:
  - IDLE: waiting for start.
  - RUN: presenting idx.
  - GAP: blank cycle, exists only with the optional feature.
- IDLE -> RUN:
  - start=1 and stop=0 at edge T.
  - At T+1: idx=0, idx_valid=1, step=1, busy=1. D, L and mode_cont are latched.
  - Dwell counter loads D.
- In RUN:
  - While the counter is nonzero, it decrements and idx is held; step=0.
  - When the counter reaches 0 and idx<L, the next cycle presents idx+1 with step=1 and the counter reloads D. Each index is therefore valid for exactly D+1 cycles. D=0 gives one cycle per index.
- End of index L:
  - mode_cont=1: wrap. The next cycle presents idx=0 with step=1; no done pulse.
  - mode_cont=0: the next cycle goes to IDLE with idx_valid=0, busy=0, done=1 for exactly one cycle. idx retains L.
- L=0: only index 0 is scanned. In continuous mode step re-pulses every D+1 cycles on index 0.
- L=M-1: full range. Wrap from M-1 to 0 uses N-bit modulo arithmetic; no overflow flag.
- start while busy is ignored. Latched D, L and mode are unchanged.
- Changing dwell, last_idx or mode_cont mid-scan has no effect until the next accepted start.
- stop=1 in any non-IDLE state: the next cycle goes to IDLE with idx_valid=0, busy=0, step=0, done=0. idx is held.
- stop and start together in IDLE: stop wins; the block stays IDLE.
- stop on the same edge the last index completes in single mode: stop wins; no done.
- Reset asserted mid-scan: immediate return to reset values; no done.

Optional Feature:
- Macro: SCAN_BLANK_EN.
- Defined:
  - Between consecutive indices, including the continuous wrap L->0, a GAP state inserts exactly one cycle with idx_valid=0. idx keeps the old value during that cycle.
  - The new index follows with step=1.
  - No gap before index 0 of a fresh start. No gap after L in single mode; done follows directly.
  - stop in GAP behaves as in RUN.
  - Period per index becomes D+2 cycles.
- Undefined: the GAP state and its logic are absent; timing is as above.

Test Plan:
- Reset: rst_n=0 mid-scan at idx=3 -> same cycle, asynchronously: idx=0, idx_valid=0, busy=0, done=0, step=0.
- Single pass: D=2, L=3, mode_cont=0, start at T -> idx sequence 0,1,2,3, each valid 3 cycles from T+1. step pulses at T+1, T+4, T+7, T+10. done=1 at T+13, idx_valid=0, busy=0.
- Continuous with wrap: D=0, L=15 (N=4), mode_cont=1 -> idx 0..15 then 0 with no gap; step every cycle; done never asserts over 40 cycles.
- Stop and start interactions: stop at idx=2 in continuous mode -> next cycle idx_valid=0, busy=0, no done. A start asserted at the mid-scan point of a separate scan -> ignored; sequence unchanged.
- Boundaries: L=0, D=1, single -> idx 0 valid 2 cycles, then done. start+stop together in IDLE -> stays IDLE. stop on the final-index completion edge -> no done.
- SCAN_BLANK_EN: D=1, L=2, single -> valid pattern 1,1,0,1,1,0,1,1, then done. idx during the blank cycles = 0 and 1 respectively.
